// File: rtl/collision_scanner.sv
// Sequential player-vs-bullets hitbox scanner: snapshot on start, one slot per clock.
// Optional COLLISION_EARLY_EXIT_EN: stop at the first hit instead of scanning every slot.

module collision_axis #(
    parameter int COORD_W = 8
) (
    input  logic [COORD_W-1:0] p,
    input  logic [COORD_W-1:0] lp,
    input  logic [COORD_W-1:0] b,
    input  logic [COORD_W-1:0] lb,
    output logic               hit
);
    logic [COORD_W-1:0] diff;
    logic [COORD_W:0]   half_sum;

    // Larger-minus-smaller keeps the distance exact; the half-sum needs the carry bit.
    always_comb begin
        diff     = (p >= b) ? (p - b) : (b - p);
        half_sum = {1'b0, lp >> 1} + {1'b0, lb >> 1};
        hit      = ({1'b0, diff} <= half_sum);
    end
endmodule

module collision_scanner #(
    parameter int COORD_W   = 8,
    parameter int N_BULLETS = 8,
    parameter int IDX_W     = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [COORD_W-1:0]           px,
    input  logic [COORD_W-1:0]           py,
    input  logic [COORD_W-1:0]           lpx,
    input  logic [COORD_W-1:0]           lpy,
    input  logic [N_BULLETS*COORD_W-1:0] bx,
    input  logic [N_BULLETS*COORD_W-1:0] by,
    input  logic [N_BULLETS*COORD_W-1:0] lbx,
    input  logic [N_BULLETS*COORD_W-1:0] lby,
    input  logic [N_BULLETS-1:0]         bValid,
    output logic                         busy,
    output logic                         isDone,
    output logic                         isCollide,
    output logic [N_BULLETS-1:0]         hitMask,
    output logic [IDX_W-1:0]             hitIdx,
    output logic [IDX_W:0]               hitCount
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BULLETS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] lx;
        logic [COORD_W-1:0] ly;
    } box_t;

    state_t state, state_nxt;
    logic   load, step, finish;

    box_t                              player_q;
    logic [N_BULLETS-1:0][COORD_W-1:0] bx_q, by_q, lbx_q, lby_q;
    logic [N_BULLETS-1:0]              valid_q;
    logic [IDX_W-1:0]                  idx;

    // Lane 0 is the X axis, lane 1 the Y axis, both looking at slot idx.
    logic [1:0][COORD_W-1:0] ax_p, ax_lp, ax_b, ax_lb;
    logic [1:0]              ax_hit;
    logic                    slot_hit;

    assign ax_p  = {player_q.y,  player_q.x};
    assign ax_lp = {player_q.ly, player_q.lx};
    assign ax_b  = {by_q[idx],   bx_q[idx]};
    assign ax_lb = {lby_q[idx],  lbx_q[idx]};

    generate
        for (genvar a = 0; a < 2; a++) begin : g_axis
            collision_axis #(.COORD_W(COORD_W)) u_axis (
                .p   (ax_p[a]),
                .lp  (ax_lp[a]),
                .b   (ax_b[a]),
                .lb  (ax_lb[a]),
                .hit (ax_hit[a])
            );
        end
    endgenerate

    assign slot_hit = valid_q[idx] & ax_hit[0] & ax_hit[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                step = 1'b1;
`ifdef COLLISION_EARLY_EXIT_EN
                if (slot_hit || idx == LAST) state_nxt = DONE;
`else
                if (idx == LAST) state_nxt = DONE;
`endif
            end
            DONE: begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            player_q  <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            lbx_q     <= '0;
            lby_q     <= '0;
            valid_q   <= '0;
            idx       <= '0;
            busy      <= 1'b0;
            isDone    <= 1'b0;
            isCollide <= 1'b0;
            hitMask   <= '0;
            hitIdx    <= '0;
            hitCount  <= '0;
        end else begin
            isDone <= finish;
            if (load) begin
                player_q  <= '{x: px, y: py, lx: lpx, ly: lpy};
                bx_q      <= bx;
                by_q      <= by;
                lbx_q     <= lbx;
                lby_q     <= lby;
                valid_q   <= bValid;
                idx       <= '0;
                busy      <= 1'b1;
                isCollide <= 1'b0;
                hitMask   <= '0;
                hitIdx    <= '0;
                hitCount  <= '0;
            end
            if (step) begin
                idx <= idx + 1'b1;
                if (slot_hit) begin
                    hitMask[idx] <= 1'b1;
                    hitCount     <= hitCount + 1'b1;
                    isCollide    <= 1'b1;
                    // isCollide still low means this is the first hit of the scan.
                    if (!isCollide) hitIdx <= idx;
                end
            end
            if (finish) busy <= 1'b0;
        end
    end
endmodule

// File: tb/tb_collision_scanner.sv
// Randomized bench for collision_scanner against a whole-scan reference model.
// Honors COLLISION_EARLY_EXIT_EN the same way the design does.

module tb_collision_scanner;
    localparam int NB = 8;
    localparam int CW = 8;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   start = 1'b0;
    logic [CW-1:0]          px = '0, py = '0, lpx = '0, lpy = '0;
    logic [NB-1:0][CW-1:0]  bx = '0, by = '0, lbx = '0, lby = '0;
    logic [NB-1:0]          bValid = '0;
    logic                   busy, isDone, isCollide;
    logic [NB-1:0]          hitMask;
    logic [2:0]             hitIdx;
    logic [3:0]             hitCount;

    int n_cmp = 0;
    int n_bad = 0;

    collision_scanner #(.COORD_W(CW), .N_BULLETS(NB), .IDX_W(3)) dut (
        .clk(clk), .reset(reset), .start(start),
        .px(px), .py(py), .lpx(lpx), .lpy(lpy),
        .bx(bx), .by(by), .lbx(lbx), .lby(lby), .bValid(bValid),
        .busy(busy), .isDone(isDone), .isCollide(isCollide),
        .hitMask(hitMask), .hitIdx(hitIdx), .hitCount(hitCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Whole-scan result straight from the geometry rules, plus the expected latency.
    function automatic void compute(output logic [NB-1:0] mask, output logic [3:0] cnt,
                                    output logic [2:0] fidx, output int lat);
        int first, dx, dy, hx, hy;
        mask = '0; cnt = '0; first = -1;
        for (int k = 0; k < NB; k++) begin
            dx = int'(px) - int'(bx[k]); if (dx < 0) dx = -dx;
            dy = int'(py) - int'(by[k]); if (dy < 0) dy = -dy;
            hx = int'(lpx) / 2 + int'(lbx[k]) / 2;
            hy = int'(lpy) / 2 + int'(lby[k]) / 2;
            if (bValid[k] && dx <= hx && dy <= hy) begin
                mask[k] = 1'b1;
                cnt++;
                if (first < 0) first = k;
            end
        end
        lat = NB + 1;
`ifdef COLLISION_EARLY_EXIT_EN
        if (first >= 0) begin
            mask = '0; mask[first] = 1'b1; cnt = 4'd1; lat = first + 2;
        end
`endif
        fidx = (first < 0) ? 3'd0 : 3'(first);
    endfunction

    logic          m_busy = 0, m_done = 0, m_coll = 0;
    logic [NB-1:0] m_mask = '0, r_mask = '0;
    logic [2:0]    m_idx = '0, r_idx = '0;
    logic [3:0]    m_cnt = '0, r_cnt = '0;
    int            m_t = 0, m_lat = 0;

    always @(posedge clk or posedge reset) begin
        logic [NB-1:0] cm; logic [3:0] cc; logic [2:0] ci; int cl;
        if (reset) begin
            m_busy <= 0; m_done <= 0; m_coll <= 0;
            m_mask <= '0; m_idx <= '0; m_cnt <= '0; m_t <= 0;
        end else begin
            m_done <= 0;
            if (m_busy) begin
                m_t <= m_t + 1;
                if (m_t + 1 == m_lat) begin
                    m_done <= 1; m_busy <= 0;
                    m_mask <= r_mask; m_idx <= r_idx; m_cnt <= r_cnt; m_coll <= (r_mask != 0);
                end
            end else if (start) begin
                compute(cm, cc, ci, cl);
                r_mask <= cm; r_cnt <= cc; r_idx <= ci; m_lat <= cl;
                m_busy <= 1; m_t <= 0;
                m_mask <= '0; m_idx <= '0; m_cnt <= '0; m_coll <= 0;
            end
        end
    end

    // Control outputs every cycle; results whenever no scan is in flight.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("isDone", 32'(isDone), 32'(m_done));
        if (!m_busy) begin
            chk("hitMask", 32'(hitMask), 32'(m_mask));
            chk("hitIdx", 32'(hitIdx), 32'(m_idx));
            chk("hitCount", 32'(hitCount), 32'(m_cnt));
            chk("isCollide", 32'(isCollide), 32'(m_coll));
        end
    end

    task automatic set_far();
        for (int k = 0; k < NB; k++) begin
            bx[k] = 8'd10; by[k] = 8'd10; lbx[k] = 8'd2; lby[k] = 8'd2;
        end
        bValid = '1;
    endtask

    task automatic set_player(input int x, input int y, input int lx, input int ly);
        px = 8'(x); py = 8'(y); lpx = 8'(lx); lpy = 8'(ly);
    endtask

    task automatic set_slot(input int k, input int x, input int y, input int lx, input int ly);
        bx[k] = 8'(x); by[k] = 8'(y); lbx[k] = 8'(lx); lby[k] = 8'(ly);
    endtask

    task automatic do_scan(input string nm, input logic [7:0] em, input int ei, input int ec, input int el);
        int n; bit got;
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        n = 0; got = 0;
        while (!got && n < 40) begin
            @(posedge clk); n++;
            #1 if (isDone) got = 1;
        end
        chk({nm, " done"}, 32'(got), 32'd1);
        chk({nm, " latency"}, 32'(n), 32'(el));
        chk({nm, " hitMask"}, 32'(hitMask), 32'(em));
        chk({nm, " hitIdx"}, 32'(hitIdx), 32'(ei));
        chk({nm, " hitCount"}, 32'(hitCount), 32'(ec));
        chk({nm, " isCollide"}, 32'(isCollide), 32'(em != 0));
        repeat (2) @(posedge clk);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1 if (isDone) cnt++;
        end
    endtask

    initial begin
        int cnt, last, edge_n;
        int times[$];

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset isDone", 32'(isDone), 32'd0);
        chk("reset hitMask", 32'(hitMask), 32'd0);
        chk("reset hitIdx", 32'(hitIdx), 32'd0);
        chk("reset hitCount", 32'(hitCount), 32'd0);
        chk("reset isCollide", 32'(isCollide), 32'd0);

        // Single hit at slot 3
        set_far(); set_player(100, 100, 10, 10); set_slot(3, 104, 102, 6, 6);
`ifdef COLLISION_EARLY_EXIT_EN
        do_scan("single", 8'h08, 3, 1, 5);
`else
        do_scan("single", 8'h08, 3, 1, 9);
`endif

        // Touching edges hit; one unit further misses
        set_far(); set_player(50, 50, 10, 10); set_slot(0, 58, 50, 6, 6);
`ifdef COLLISION_EARLY_EXIT_EN
        do_scan("touch", 8'h01, 0, 1, 2);
`else
        do_scan("touch", 8'h01, 0, 1, 9);
`endif
        set_slot(0, 59, 50, 6, 6);
        do_scan("miss", 8'h00, 0, 0, 9);

        // Distance across the 0/255 boundary must not wrap
        set_far(); set_player(2, 2, 8, 8); set_slot(0, 250, 2, 8, 8);
        do_scan("wrap", 8'h00, 0, 0, 9);

        // Multiple hits plus an overlapping but invalid slot
        set_far(); set_player(100, 100, 10, 10);
        set_slot(1, 100, 100, 4, 4); set_slot(4, 98, 103, 4, 4);
        set_slot(6, 105, 95, 4, 4); set_slot(5, 100, 100, 4, 4);
        bValid[5] = 1'b0;
`ifdef COLLISION_EARLY_EXIT_EN
        do_scan("multi", 8'h02, 1, 1, 3);
`else
        do_scan("multi", 8'h52, 1, 3, 9);
`endif

        // Hits at slots 2 and 5
        set_far(); set_player(100, 100, 10, 10);
        set_slot(2, 100, 100, 4, 4); set_slot(5, 101, 99, 4, 4);
`ifdef COLLISION_EARLY_EXIT_EN
        do_scan("two", 8'h04, 2, 1, 4);
`else
        do_scan("two", 8'h24, 2, 2, 9);
`endif

        // start re-pulsed mid-scan is ignored
        set_far(); set_player(100, 100, 10, 10); set_slot(3, 104, 102, 6, 6);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        count_done(20, cnt);
        chk("restart ignored", 32'(cnt), 32'd1);

        // Reset mid-scan aborts with no isDone
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hitMask", 32'(hitMask), 32'd0);
        chk("abort hitCount", 32'(hitCount), 32'd0);
        chk("abort isCollide", 32'(isCollide), 32'd0);
        @(posedge clk); #2 reset = 1'b0;
        count_done(15, cnt);
        chk("abort no done", 32'(cnt), 32'd0);

        // start held high: one scan every N_BULLETS+2 cycles
        set_far(); set_player(100, 100, 10, 10);
        @(posedge clk); #2 start = 1'b1;
        edge_n = 0;
        repeat (45) begin
            @(posedge clk); edge_n++;
            #1 if (isDone) times.push_back(edge_n);
        end
        #1 start = 1'b0;
        chk("held count", 32'(times.size() >= 4), 32'd1);
        last = -1;
        foreach (times[i]) begin
            if (last >= 0) chk("held period", 32'(times[i] - last), 32'd10);
            last = times[i];
        end
        repeat (12) @(posedge clk);

        // Random traffic: inputs churn every cycle, starts and rare resets
        repeat (1500) begin
            @(posedge clk);
            #2;
            px = 8'($urandom); py = 8'($urandom);
            lpx = 8'($urandom_range(0, 40)); lpy = 8'($urandom_range(0, 40));
            for (int k = 0; k < NB; k++) begin
                if ($urandom_range(0, 4) == 0) begin
                    bx[k] = 8'($urandom); by[k] = 8'($urandom);
                end else begin
                    bx[k] = 8'(int'(px) + $urandom_range(0, 40) - 20);
                    by[k] = 8'(int'(py) + $urandom_range(0, 40) - 20);
                end
                lbx[k] = 8'($urandom_range(0, 30));
                lby[k] = 8'($urandom_range(0, 30));
            end
            bValid = NB'($urandom);
            start = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 299) == 0);
        end
        #1 start = 1'b0; reset = 1'b0;
        repeat (15) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Sequential multi-bullet collision engine for the bullet-hell combat phase.
- Snapshots the player hitbox and N_BULLETS bullet hitboxes on `start`, then tests one bullet per clock against the player.
- Reports a hit mask, the first-hit index, the hit count and a one-cycle `isDone` pulse.
- Sits between the bullet pattern generator and the HP/damage logic; replaces the single-pair combinational check.

Parameters:
- COORD_W, 8: width of every coordinate and size field.
- N_BULLETS, 8: number of bullet slots scanned per request (≥1).
- IDX_W, 3: width of hitIdx; must satisfy 2**IDX_W ≥ N_BULLETS.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  scan request, sampled on clk edge.
- px, py  in  COORD_W  player hitbox centre.
- lpx, lpy  in  COORD_W  player hitbox full width/height.
- bx, by  in  N_BULLETS*COORD_W  bullet centres; slot k occupies bits [k*COORD_W +: COORD_W].
- lbx, lby  in  N_BULLETS*COORD_W  bullet full sizes, same packing.
- bValid  in  N_BULLETS  per-slot active flag.
- busy  out  1  high while scanning.
- isDone  out  1  one-cycle pulse when results become valid.
- isCollide  out  1  OR of hitMask.
- hitMask  out  N_BULLETS  per-slot hit flags.
- hitIdx  out  IDX_W  lowest hit slot index.
- hitCount  out  IDX_W+1  number of hit slots.

Behaviour:
- Reset, asynchronous: state=IDLE, idx=0, busy=0, isDone=0, isCollide=0, hitMask=0, hitIdx=0, hitCount=0, snapshot registers=0.
- FSM states: IDLE, SCAN, DONE.
- IDLE with start=1:
  - Latch all position, size and bValid inputs into snapshot registers.
  - Clear hitMask, hitIdx and hitCount; set idx=0.
  - Move to SCAN; busy=1 from the next cycle.
- SCAN, each cycle, evaluates slot idx from the snapshot:
  - Per-axis overlap: |p−b| ≤ (lp>>1)+(lb>>1).
  - The absolute difference is computed in COORD_W bits as the larger operand minus the smaller, with no wrap-around.
  - The half-sum is computed in COORD_W+1 bits.
  - Touching edges (equality) count as a hit.
  - Hit = bValid[idx] & overlapX & overlapY.
  - On hit: set hitMask[idx]; increment hitCount; if this is the first hit of the scan, load hitIdx=idx.
  - If idx==N_BULLETS−1, go to DONE; otherwise idx+1.
- DONE, one cycle: isDone=1, busy=0, then return to IDLE.
- Latency: isDone is high exactly N_BULLETS+1 cycles after the edge that sampled start.
- Results hold until the next accepted start or reset.
- isCollide is registered, updated together with hitMask.
- start while in SCAN or DONE is ignored, not queued.
- start held high continuously starts a new scan on the IDLE cycle after each DONE.
- Inputs changing during a scan have no effect; only the snapshot is used.
- Reset asserted mid-scan aborts immediately to reset values; no isDone is produced.
- No hit: hitIdx=0, hitCount=0, isCollide=0. Qualify hitIdx with isCollide.
- Slots with bValid=0 never hit, regardless of geometry.

Optional Feature:
- Macro: COLLISION_EARLY_EXIT_EN.
- Defined: in SCAN, the first hit records its slot, then goes directly to DONE.
  - hitMask has exactly one bit set and hitCount=1.
  - isDone arrives k+2 cycles after the start edge for a first hit at slot k.
  - With no hit, latency is unchanged.
- Undefined: a full scan of all slots every time, as described above.

Test Plan:
Defaults apply (COORD_W=8, N_BULLETS=8) unless stated.
- Single hit: player (100,100,10,10); slot 3 at (104,102,6,6) valid; all others far (10,10,2,2) → isDone at cycle 9, hitMask=8'h08, hitIdx=3, hitCount=1, isCollide=1.
- Edge touch vs. miss: player (50,50,10,10); slot 0 at (58,50,6,6) → hit (diff 8 = 5+3); slot 0 moved to (59,50) → no hit, isCollide=0.
- Wrap-around guard: player (2,2,8,8); slot 0 at (250,2,8,8) valid → no hit. An 8-bit subtraction bug would report a hit here.
- Multiple hits and invalid slot: slots 1, 4, 6 overlap the player and slot 5 overlaps with bValid[5]=0 → hitMask=8'h52, hitIdx=1, hitCount=3.
- Control hazards:
  - start pulsed again at cycle 3 of a scan → ignored, single isDone.
  - reset asserted at cycle 4 → all outputs 0, no isDone.
  - start held high → isDone every 10 cycles.
- COLLISION_EARLY_EXIT_EN defined, hits at slots 2 and 5 → isDone at cycle 4, hitMask=8'h04, hitIdx=2, hitCount=1.
